// File: rtl/mul_share_sched_pkg.sv
// mul_sched_pkg: shared types and constants for the multiplier-sharing scheduler.
//   state_t  : scheduler FSM states (IDLE -> COMPUTE -> RESPOND -> IDLE)
//   OPW      : operand width of the shared multiplier
//   PRODW    : product width of the shared multiplier
//   idx_of() : index of the set bit in a one-hot vector of up to 8 bits
package mul_sched_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPUTE = 2'd1,
        RESPOND = 2'd2
    } state_t;

    localparam int OPW   = 8;
    localparam int PRODW = 16;

    // Returns 0 for an all-zero vector; callers only use the result
    // when the vector is known to have a bit set.
    function automatic logic [2:0] idx_of(input logic [7:0] onehot);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (onehot[i]) begin
                idx = 3'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/mul_share_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin arbiter.
//   req       in  N         request vector
//   ptr       in  clog2(N)  highest-priority position this cycle
//   grant     out N         one-hot grant (all zero when no request)
//   grant_idx out clog2(N)  index of the granted bit
// The request vector is rotated so that bit ptr lands at position 0,
// a fixed lowest-index-wins priority picks one bit, and the one-hot
// result is rotated back into the original bit positions.
module rr_arbiter
    import mul_sched_pkg::*;
#(
    parameter int N  = 4,
    localparam int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] grant_idx
);

    logic [2*N-1:0] dbl_req;
    logic [N-1:0]   rot_req;
    logic [N-1:0]   rot_gnt;
    logic [2*N-1:0] dbl_gnt;

    always_comb begin
        dbl_req = {req, req} >> ptr;
        rot_req = dbl_req[N-1:0];

        // Scan from the top so the lowest set bit is the last one written.
        rot_gnt = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (rot_req[i]) begin
                rot_gnt = N'(1) << i;
            end
        end

        dbl_gnt   = {rot_gnt, rot_gnt} << ptr;
        grant     = dbl_gnt[2*N-1:N];
        grant_idx = PW'(idx_of(8'(grant)));
    end

endmodule

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin scheduler sharing one external 8x8 unsigned
// multiplier among NREQ requesters.
//   clk        in  1        rising-edge clock
//   rst_n      in  1        synchronous active-low reset
//   req_valid  in  NREQ     per-requester request valid
//   req_a      in  8*NREQ   multiplicands, requester i at [8i+7:8i]
//   req_b      in  8*NREQ   multipliers, same packing
//   req_ready  out NREQ     one-hot accept strobe (IDLE only)
//   resp_valid out 1        product available
//   resp_ready in  1        consumer accepts product
//   resp_prod  out 16       registered product
//   resp_id    out IDW      requester owning resp_prod
//   mul_a      out 8        operand register to the shared multiplier
//   mul_b      out 8        operand register to the shared multiplier
//   mul_prod   in  16       product from the shared multiplier
//   busy       out 1        high whenever the FSM is not IDLE
// A transaction holds mul_a/mul_b stable for MUL_LAT cycles so the
// multiplier array may be constrained as a multicycle path, then samples
// mul_prod unmodified into resp_prod.
module mul_share_sched
    import mul_sched_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int MUL_LAT = 2,
    parameter int IDW     = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [OPW*NREQ-1:0] req_a,
    input  logic [OPW*NREQ-1:0] req_b,
    output logic [NREQ-1:0]     req_ready,
    output logic                resp_valid,
    input  logic                resp_ready,
    output logic [PRODW-1:0]    resp_prod,
    output logic [IDW-1:0]      resp_id,
    output logic [OPW-1:0]      mul_a,
    output logic [OPW-1:0]      mul_b,
    input  logic [PRODW-1:0]    mul_prod,
    output logic                busy
);

    // Wide enough for MUL_LAT up to 15.
    localparam int CNTW = 4;

    state_t          state;
    logic [IDW-1:0]  rr_ptr;
    logic [CNTW-1:0] wait_cnt;

    logic [NREQ-1:0] grant;
    logic [IDW-1:0]  grant_idx;
    logic            accept;

    rr_arbiter #(
        .N (NREQ)
    ) u_arb (
        .req       (req_valid),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // The grant is offered only in IDLE; since it is derived from
    // req_valid, any offered bit is also a completed handshake.
    assign req_ready = (rst_n && state == IDLE) ? grant : '0;
    assign accept    = |req_ready;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rr_ptr     <= '0;
            wait_cnt   <= '0;
            mul_a      <= '0;
            mul_b      <= '0;
            resp_prod  <= '0;
            resp_id    <= '0;
            resp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        mul_a    <= req_a[OPW*int'(grant_idx) +: OPW];
                        mul_b    <= req_b[OPW*int'(grant_idx) +: OPW];
                        resp_id  <= grant_idx;
                        if (int'(grant_idx) == NREQ - 1) begin
                            rr_ptr <= '0;
                        end else begin
                            rr_ptr <= grant_idx + 1'b1;
                        end
                        wait_cnt <= CNTW'(MUL_LAT - 1);
                        state    <= COMPUTE;
                    end
                end

                COMPUTE: begin
                    if (wait_cnt == '0) begin
                        resp_prod  <= mul_prod;
                        resp_valid <= 1'b1;
                        state      <= RESPOND;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end

                RESPOND: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mul_share_sched.sv
module tb_mul_share_sched;

    localparam int NREQ    = 4;
    localparam int MUL_LAT = 2;
    localparam int IDW     = 2;

    logic              clk;
    logic              rst_n;
    logic [NREQ-1:0]   req_valid;
    logic [8*NREQ-1:0] req_a;
    logic [8*NREQ-1:0] req_b;
    logic [NREQ-1:0]   req_ready;
    logic              resp_valid;
    logic              resp_ready;
    logic [15:0]       resp_prod;
    logic [IDW-1:0]    resp_id;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [15:0]       mul_prod;
    logic              busy;

    int checks = 0;
    int errors = 0;
    logic [NREQ-1:0] last_hs;

    mul_share_sched #(
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT),
        .IDW     (IDW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_prod  (resp_prod),
        .resp_id    (resp_id),
        .mul_a      (mul_a),
        .mul_b      (mul_b),
        .mul_prod   (mul_prod),
        .busy       (busy)
    );

    // Stand-in for the external shared multiplier.
    assign mul_prod = {8'd0, mul_a} * {8'd0, mul_b};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One clock: sample the handshake at the negedge, let the posedge happen,
    // then drop valid for any requester that was just accepted.
    task automatic step();
        logic [NREQ-1:0] hs;
        @(negedge clk);
        hs = req_valid & req_ready;
        @(posedge clk);
        #1;
        req_valid = req_valid & ~hs;
        last_hs   = hs;
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
        req_valid[i]    = 1'b1;
    endtask

    task automatic wait_resp(input string tag, input int exp_id, input int exp_prod);
        int n;
        n = 0;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        chk({tag, "_valid"}, 32'(resp_valid), 32'd1);
        chk({tag, "_prod"}, 32'(resp_prod), 32'(exp_prod));
        chk({tag, "_id"}, 32'(resp_id), 32'(exp_id));
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
    endtask

    initial begin
        int n;
        int seen;
        rst_n      = 1'b0;
        req_valid  = '0;
        req_a      = '0;
        req_b      = '0;
        resp_ready = 1'b0;
        last_hs    = '0;

        // Reset state
        step();
        step();
        chk("rst_resp_valid", 32'(resp_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_req_ready", 32'(req_ready), 0);
        chk("rst_mul_a", 32'(mul_a), 0);
        chk("rst_mul_b", 32'(mul_b), 0);
        chk("rst_resp_prod", 32'(resp_prod), 0);
        chk("rst_resp_id", 32'(resp_id), 0);
        rst_n = 1'b1;
        step();

        // Single request, requester 0: 30*100 = 3000, latency MUL_LAT+1 edges
        set_req(0, 8'd30, 8'd100);
        #1;
        chk("single_req_ready", 32'(req_ready), 32'b0001);
        step();
        chk("single_hs", 32'(last_hs), 32'b0001);
        chk("single_mul_a", 32'(mul_a), 30);
        chk("single_mul_b", 32'(mul_b), 100);
        chk("single_busy", 32'(busy), 1);
        chk("single_ready_low", 32'(req_ready), 0);
        n = 1;
        while (!resp_valid && n < 20) begin
            step();
            n++;
        end
        chk("single_latency", 32'(n), 32'(MUL_LAT + 1));
        wait_resp("single", 0, 3000);
        chk("single_idle", 32'(busy), 0);

        // Max operands, requester 2: 255*255 = 65025
        set_req(2, 8'd255, 8'd255);
        wait_resp("max", 2, 65025);

        // Pointer now 3; only 1 and 3 valid: 3 first (3*... 10*20=200), then 1 (3*4=12)
        set_req(1, 8'd3, 8'd4);
        set_req(3, 8'd10, 8'd20);
        wait_resp("wrap_first", 3, 200);
        wait_resp("wrap_second", 1, 12);

        // Reset during COMPUTE: transaction discarded, pointer back to 0
        set_req(2, 8'd9, 8'd9);
        step();
        chk("rstmid_hs", 32'(last_hs), 32'b0100);
        chk("rstmid_busy_pre", 32'(busy), 1);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("rstmid_mul_a", 32'(mul_a), 0);
        chk("rstmid_mul_b", 32'(mul_b), 0);
        chk("rstmid_busy", 32'(busy), 0);
        chk("rstmid_valid", 32'(resp_valid), 0);
        chk("rstmid_prod", 32'(resp_prod), 0);
        chk("rstmid_id", 32'(resp_id), 0);
        seen = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            if (resp_valid) seen++;
        end
        chk("rstmid_no_resp", 32'(seen), 0);

        // Round robin from pointer 0 with all four valid
        set_req(0, 8'd131, 8'd72);
        set_req(1, 8'd0, 8'd74);
        set_req(2, 8'd127, 8'd127);
        set_req(3, 8'd1, 8'd127);
        #1;
        chk("rr_first_grant", 32'(req_ready), 32'b0001);
        wait_resp("rr0", 0, 9432);
        wait_resp("rr1", 1, 0);
        wait_resp("rr2", 2, 16129);
        wait_resp("rr3", 3, 127);

        // Backpressure: 0 then 1 pending; pointer back at 0 so 0 goes first
        set_req(0, 8'd5, 8'd6);
        set_req(1, 8'd7, 8'd8);
        n = 0;
        while (!resp_valid && n < 40) begin
            step();
            n++;
        end
        for (int k = 0; k < 5; k++) begin
            chk("bp_valid", 32'(resp_valid), 1);
            chk("bp_prod", 32'(resp_prod), 30);
            chk("bp_id", 32'(resp_id), 0);
            chk("bp_req_ready", 32'(req_ready), 0);
            step();
        end
        chk("bp_req1_pending", 32'(req_valid), 32'b0010);
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        #1;
        chk("bp_released", 32'(resp_valid), 0);
        chk("bp_ready1", 32'(req_ready), 32'b0010);
        step();
        chk("bp_hs1", 32'(last_hs), 32'b0010);
        wait_resp("bp_second", 1, 56);

        // resp_ready outside RESPOND is ignored
        resp_ready = 1'b1;
        step();
        step();
        resp_ready = 1'b0;
        chk("idle_ready_ignored", 32'(resp_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
